// File: rtl/tick_timer_bank_if.sv
// Control/status bundle for tick_timer_bank: per-channel strobes, periods and status.
interface tick_timer_bank_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 8
);
  logic                      en;
  logic [NUM_CH-1:0]         load;
  logic [NUM_CH-1:0]         mode;
  logic [NUM_CH*CNT_W-1:0]   period_in;
  logic [NUM_CH-1:0]         stop;
  logic                      tick;
  logic [NUM_CH-1:0]         busy;
  logic [NUM_CH-1:0]         expire;
  logic [NUM_CH*CNT_W-1:0]   remain;

  modport master (
    output en, load, mode, period_in, stop,
    input  tick, busy, expire, remain
  );

  modport slave (
    input  en, load, mode, period_in, stop,
    output tick, busy, expire, remain
  );
endinterface

// File: rtl/tick_timer_bank.sv
// Shared free-running prescaler producing a base tick, feeding NUM_CH independent
// one-shot/periodic down-counting channels with registered expiry pulses.
module tick_timer_bank #(
  parameter int unsigned CLK_PER_TICK = 10,
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned CNT_W        = 8
) (
  input  logic              clk,
  input  logic              rst,
  tick_timer_bank_if.slave  bus
);

  localparam int unsigned PRE_W = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_PER_TICK - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ch_state_e;

  logic [PRE_W-1:0] pre_q, pre_d;
  logic             tick_q, tick_d;
  logic             wrap;

  ch_state_e        state_q  [NUM_CH];
  ch_state_e        state_d  [NUM_CH];
  logic [CNT_W-1:0] remain_q [NUM_CH];
  logic [CNT_W-1:0] remain_d [NUM_CH];
  logic [CNT_W-1:0] period_q [NUM_CH];
  logic [CNT_W-1:0] period_d [NUM_CH];
  logic [CNT_W-1:0] pin      [NUM_CH];
  logic [NUM_CH-1:0] mode_q, mode_d;
  logic [NUM_CH-1:0] expire_q, expire_d;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q    <= '0;
      tick_q   <= 1'b0;
      mode_q   <= '0;
      expire_q <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        state_q[i]  <= IDLE;
        remain_q[i] <= '0;
        period_q[i] <= '0;
      end
    end else begin
      pre_q    <= pre_d;
      tick_q   <= tick_d;
      mode_q   <= mode_d;
      expire_q <= expire_d;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        state_q[i]  <= state_d[i];
        remain_q[i] <= remain_d[i];
        period_q[i] <= period_d[i];
      end
    end
  end

  // Prescaler next state
  always_comb begin
    wrap   = bus.en && (pre_q == PRE_MAX);
    pre_d  = pre_q;
    tick_d = 1'b0;
    if (wrap) begin
      pre_d  = '0;
      tick_d = 1'b1;
    end else if (bus.en) begin
      pre_d = pre_q + PRE_W'(1);
    end
  end

  // Channel next state; priority stop > load > wrap
  always_comb begin
    mode_d   = mode_q;
    expire_d = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      pin[i]      = bus.period_in[i*CNT_W +: CNT_W];
      state_d[i]  = state_q[i];
      remain_d[i] = remain_q[i];
      period_d[i] = period_q[i];
      if (bus.stop[i]) begin
        state_d[i]  = IDLE;
        remain_d[i] = '0;
      end else if (bus.load[i] && (pin[i] != '0)) begin
        state_d[i]  = RUN;
        remain_d[i] = pin[i];
        period_d[i] = pin[i];
        mode_d[i]   = bus.mode[i];
      end else if ((state_q[i] == RUN) && wrap) begin
        if (remain_q[i] == CNT_W'(1)) begin
          expire_d[i] = 1'b1;
          if (mode_q[i]) begin
            remain_d[i] = period_q[i];
          end else begin
            remain_d[i] = '0;
            state_d[i]  = IDLE;
          end
        end else begin
          remain_d[i] = remain_q[i] - CNT_W'(1);
        end
      end
    end
  end

  // Outputs straight from registers
  always_comb begin
    bus.tick   = tick_q;
    bus.expire = expire_q;
    bus.busy   = '0;
    bus.remain = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      bus.busy[i]                    = (state_q[i] == RUN);
      bus.remain[i*CNT_W +: CNT_W]   = remain_q[i];
    end
  end

endmodule

// File: tb/tb_tick_timer_bank.sv
// Directed bench for tick_timer_bank with CLK_PER_TICK=10, NUM_CH=4, CNT_W=8.
module tb_tick_timer_bank;

  logic clk;
  logic rst;
  int   cyc;
  int   n_assert;
  int   n_fail;

  tick_timer_bank_if #(.NUM_CH(4), .CNT_W(8)) bus ();

  tick_timer_bank #(.CLK_PER_TICK(10), .NUM_CH(4), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Advance to 1 time unit after rising edge number n since reset release
  task automatic step_to(input int n);
    while (cyc < n) begin
      @(posedge clk);
      cyc++;
    end
    #1;
  endtask

  function automatic logic [7:0] rem(input int i);
    return bus.remain[i*8 +: 8];
  endfunction

  initial begin
    n_assert = 0;
    n_fail   = 0;
    cyc      = 0;
    rst           = 1'b1;
    bus.en        = 1'b0;
    bus.load      = '0;
    bus.mode      = '0;
    bus.period_in = '0;
    bus.stop      = '0;
    #1;
    chk("rst_tick",   32'(bus.tick),   0);
    chk("rst_busy",   32'(bus.busy),   0);
    chk("rst_expire", 32'(bus.expire), 0);
    chk("rst_remain", bus.remain,      0);
    #1;
    rst    = 1'b0;
    bus.en = 1'b1;

    // one-shot ch0, P=3, loaded on edge 3
    step_to(2);
    chk("t2_tick", 32'(bus.tick), 0);
    bus.load = 4'b0001;
    bus.period_in[0 +: 8] = 8'd3;
    step_to(3);
    bus.load = '0;
    chk("c0_rem3", 32'(rem(0)), 3);
    chk("c0_busy", 32'(bus.busy), 32'h1);
    step_to(9);
    chk("t9_tick", 32'(bus.tick), 0);
    step_to(10);
    chk("t10_tick", 32'(bus.tick), 1);
    chk("c0_rem2", 32'(rem(0)), 2);
    step_to(11);
    chk("t11_tick", 32'(bus.tick), 0);
    step_to(20);
    chk("t20_tick", 32'(bus.tick), 1);
    chk("c0_rem1", 32'(rem(0)), 1);
    step_to(29);
    chk("c0_noexp29", 32'(bus.expire), 0);
    step_to(30);
    chk("t30_tick", 32'(bus.tick), 1);
    chk("c0_exp30", 32'(bus.expire), 32'h1);
    chk("c0_rem0", 32'(rem(0)), 0);
    step_to(31);
    chk("c0_exp31", 32'(bus.expire), 0);
    chk("c0_busy31", 32'(bus.busy), 0);

    // periodic ch1, P=2, loaded on edge 32
    bus.load = 4'b0010;
    bus.mode = 4'b0010;
    bus.period_in = '0;
    bus.period_in[8 +: 8] = 8'd2;
    step_to(32);
    bus.load = '0;
    chk("c1_rem2", 32'(rem(1)), 2);
    step_to(40);
    chk("c1_rem1", 32'(rem(1)), 1);
    step_to(49);
    chk("c1_noexp49", 32'(bus.expire), 0);
    step_to(50);
    chk("c1_exp50", 32'(bus.expire), 32'h2);
    chk("c1_reload", 32'(rem(1)), 2);
    chk("c1_busy50", 32'(bus.busy), 32'h2);
    step_to(51);
    chk("c1_exp51", 32'(bus.expire), 0);
    step_to(70);
    chk("c1_exp70", 32'(bus.expire), 32'h2);
    step_to(89);
    chk("c1_noexp89", 32'(bus.expire), 0);
    step_to(90);
    chk("c1_exp90", 32'(bus.expire), 32'h2);

    // ch2 P=1 and ch3 P=2 one-shot, loaded on edge 93
    step_to(92);
    bus.load = 4'b1100;
    bus.mode = 4'b0000;
    bus.period_in = '0;
    bus.period_in[16 +: 8] = 8'd1;
    bus.period_in[24 +: 8] = 8'd2;
    step_to(93);
    bus.load = '0;
    chk("c2_rem1", 32'(rem(2)), 1);
    chk("c3_rem2", 32'(rem(3)), 2);
    chk("busy93", 32'(bus.busy), 32'hE);
    step_to(94);
    bus.stop = 4'b0010;
    step_to(95);
    bus.stop = '0;
    chk("c1_stop_busy", 32'(bus.busy), 32'hC);
    chk("c1_stop_rem", 32'(rem(1)), 0);
    step_to(99);
    bus.stop = 4'b0100;
    step_to(100);
    bus.stop = '0;
    chk("t100_tick", 32'(bus.tick), 1);
    chk("c2_stop_noexp", 32'(bus.expire), 0);
    chk("c2_stop_busy", 32'(bus.busy), 32'h8);
    chk("c2_stop_rem", 32'(rem(2)), 0);
    chk("c3_rem1", 32'(rem(3)), 1);
    step_to(109);
    bus.load = 4'b1000;
    bus.period_in = '0;
    bus.period_in[24 +: 8] = 8'd5;
    step_to(110);
    bus.load = '0;
    bus.period_in = '0;
    chk("c3_restart_noexp", 32'(bus.expire), 0);
    chk("c3_restart_rem", 32'(rem(3)), 5);
    chk("c3_restart_busy", 32'(bus.busy), 32'h8);

    // 25-cycle pause of the prescaler
    step_to(120);
    chk("c3_rem4", 32'(rem(3)), 4);
    step_to(130);
    chk("c3_rem3", 32'(rem(3)), 3);
    bus.en = 1'b0;
    step_to(140);
    chk("pause_tick", 32'(bus.tick), 0);
    chk("pause_rem", 32'(rem(3)), 3);
    bus.load = 4'b1001;
    step_to(145);
    bus.load = '0;
    chk("zero_load_rem", 32'(rem(3)), 3);
    chk("zero_load_busy", 32'(bus.busy), 32'h8);
    step_to(155);
    bus.en = 1'b1;
    step_to(160);
    chk("t160_tick", 32'(bus.tick), 0);
    chk("t160_rem", 32'(rem(3)), 3);
    step_to(164);
    chk("t164_tick", 32'(bus.tick), 0);
    step_to(165);
    chk("t165_tick", 32'(bus.tick), 1);
    chk("t165_rem", 32'(rem(3)), 2);
    step_to(175);
    chk("t175_rem", 32'(rem(3)), 1);
    step_to(184);
    chk("c3_noexp184", 32'(bus.expire), 0);
    step_to(185);
    chk("c3_exp185", 32'(bus.expire), 32'h8);
    chk("c3_busy185", 32'(bus.busy), 0);
    chk("c3_rem185", 32'(rem(3)), 0);

    // simultaneous expiry: ch0 one-shot P=1, ch2 periodic P=1
    step_to(186);
    bus.load = 4'b0101;
    bus.mode = 4'b0100;
    bus.period_in[0 +: 8]  = 8'd1;
    bus.period_in[16 +: 8] = 8'd1;
    step_to(187);
    bus.load = '0;
    bus.period_in = '0;
    chk("busy187", 32'(bus.busy), 32'h5);
    step_to(195);
    chk("multi_exp195", 32'(bus.expire), 32'h5);
    chk("busy195", 32'(bus.busy), 32'h4);
    chk("c2_reload195", 32'(rem(2)), 1);
    step_to(205);
    chk("c2_exp205", 32'(bus.expire), 32'h4);

    // async reset between edges
    #3;
    rst = 1'b1;
    #1;
    chk("arst_tick",   32'(bus.tick),   0);
    chk("arst_busy",   32'(bus.busy),   0);
    chk("arst_expire", 32'(bus.expire), 0);
    chk("arst_remain", bus.remain,      0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    cyc = 0;
    step_to(9);
    chk("post_rst_t9", 32'(bus.tick), 0);
    step_to(10);
    chk("post_rst_t10", 32'(bus.tick), 1);
    chk("post_rst_busy", 32'(bus.busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
